// File: rtl/freq_gen_nco.sv
// freq_gen_nco: programmable square-wave test-clock generator.
// A requested frequency in Hz is converted to a phase increment by a
// sequential restoring divider. The increment then drives a phase-accumulator
// NCO in the sys_clk domain.
//
// Ports:
//   sys_clk, sys_rst   standard clock, synchronous active-high reset
//   freq_set[_valid]   requested frequency (Hz) and request strobe
//   freq_set_ready     high only in IDLE; a request is accepted on valid&&ready
//   gen_en             NCO enable; 0 holds accumulator and clk_out at 0
//   clk_out            generated square wave (registered accumulator MSB)
//   freq_active        frequency currently applied
//   inc_active         phase increment currently applied
//   busy               a request is in CHECK, DIV or APPLY
//   err_range          one-cycle pulse when a request exceeds CLK_STAND_FREQ/2
//
// Build option FREQ_GEN_EDGE_CNT_EN adds edge_cnt_clr (in) and edge_cnt[47:0]
// (out), a wrapping count of clk_out rising edges.
module freq_gen_nco #(
  parameter int unsigned CLK_STAND_FREQ = 100_000_000,
  parameter int unsigned FREQ_W         = 34,
  parameter int unsigned ACC_W          = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [FREQ_W-1:0] freq_set,
  input  logic              freq_set_valid,
  output logic              freq_set_ready,
  input  logic              gen_en,
  output logic              clk_out,
  output logic [FREQ_W-1:0] freq_active,
  output logic [ACC_W-1:0]  inc_active,
  output logic              busy,
  output logic              err_range
`ifdef FREQ_GEN_EDGE_CNT_EN
  ,
  input  logic              edge_cnt_clr,
  output logic [47:0]       edge_cnt
`endif
);

  localparam int unsigned DIVD_W = FREQ_W + ACC_W;
  localparam int unsigned REM_W  = $clog2(CLK_STAND_FREQ) + 1;
  localparam int unsigned CNT_W  = $clog2(DIVD_W);

  localparam logic [FREQ_W-1:0] HALF_FREQ = FREQ_W'(CLK_STAND_FREQ / 2);
  localparam logic [REM_W:0]    DIVISOR   = (REM_W + 1)'(CLK_STAND_FREQ);
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DIVD_W - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_DIV   = 2'd2;
  localparam logic [1:0] ST_APPLY = 2'd3;

  logic [1:0]        state_q,    state_d;
  logic [FREQ_W-1:0] freq_req_q, freq_req_d;
  logic [DIVD_W-1:0] dvd_q,      dvd_d;
  logic [REM_W-1:0]  rem_q,      rem_d;
  logic [ACC_W-1:0]  quo_q,      quo_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [ACC_W-1:0]  acc_q,      acc_d;
  logic [ACC_W-1:0]  inc_q,      inc_d;
  logic [FREQ_W-1:0] freq_act_q, freq_act_d;
  logic              clk_out_q,  clk_out_d;
  logic              ready_q,    ready_d;
  logic              busy_q,     busy_d;
  logic              err_q,      err_d;

  logic [REM_W:0]    trial;
  logic              trial_ge;
  logic [ACC_W:0]    acc_sum;
  logic              acc_wrap;

  // Next-state logic: request FSM, restoring divider and NCO.
  always_comb begin
    state_d    = state_q;
    freq_req_d = freq_req_q;
    dvd_d      = dvd_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    inc_d      = inc_q;
    freq_act_d = freq_act_q;
    err_d      = 1'b0;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    trial    = {rem_q, dvd_q[DIVD_W-1]};
    trial_ge = (trial >= DIVISOR);

    // Carry out of the accumulator add marks the wrap cycle.
    acc_sum  = {1'b0, acc_q} + {1'b0, inc_q};
    acc_wrap = acc_sum[ACC_W];

    case (state_q)
      ST_IDLE: begin
        if (freq_set_valid) begin
          freq_req_d = freq_set;
          state_d    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (freq_req_q > HALF_FREQ) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (freq_req_q == '0) begin
          quo_d   = '0;
          state_d = ST_APPLY;
        end else begin
          dvd_d   = {freq_req_q, ACC_W'(0)};
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = ST_DIV;
        end
      end
      ST_DIV: begin
        dvd_d = dvd_q << 1;
        rem_d = trial_ge ? REM_W'(trial - DIVISOR) : REM_W'(trial);
        // Only the low ACC_W quotient bits are kept; upper bits are always 0.
        quo_d = {quo_q[ACC_W-2:0], trial_ge};
        if (cnt_q == LAST_STEP) begin
          state_d = ST_APPLY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_APPLY: begin
        // Swap increments on a wrap so the current cycle completes cleanly.
        if ((inc_q == '0) || !gen_en || acc_wrap) begin
          inc_d      = quo_q;
          freq_act_d = freq_req_q;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    acc_d     = gen_en ? acc_sum[ACC_W-1:0] : '0;
    clk_out_d = gen_en & acc_q[ACC_W-1];
    ready_d   = (state_d == ST_IDLE);
    busy_d    = (state_d != ST_IDLE);
  end

  // State registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      freq_req_q <= '0;
      dvd_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      inc_q      <= '0;
      freq_act_q <= '0;
      clk_out_q  <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      freq_req_q <= freq_req_d;
      dvd_q      <= dvd_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      inc_q      <= inc_d;
      freq_act_q <= freq_act_d;
      clk_out_q  <= clk_out_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

`ifdef FREQ_GEN_EDGE_CNT_EN
  logic [47:0] edge_cnt_q, edge_cnt_d;

  // Rising edge is seen when clk_out is about to go 0->1; clear has priority.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (edge_cnt_clr) begin
      edge_cnt_d = '0;
    end else if (clk_out_d && !clk_out_q) begin
      edge_cnt_d = edge_cnt_q + 48'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      edge_cnt_q <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign edge_cnt = edge_cnt_q;
`else
  // Edge counter not built.
`endif

  assign freq_set_ready = ready_q;
  assign clk_out        = clk_out_q;
  assign freq_active    = freq_act_q;
  assign inc_active     = inc_q;
  assign busy           = busy_q;
  assign err_range      = err_q;

endmodule

// File: tb/tb_freq_gen_nco.sv
// Self-checking bench for freq_gen_nco: directed steps plus randomized
// requests checked against an arithmetic reference model.
module tb_freq_gen_nco;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [33:0] freq_set;
  logic        freq_set_valid;
  logic        freq_set_ready;
  logic        gen_en;
  logic        clk_out;
  logic [33:0] freq_active;
  logic [31:0] inc_active;
  logic        busy;
  logic        err_range;
`ifdef FREQ_GEN_EDGE_CNT_EN
  logic        edge_cnt_clr;
  logic [47:0] edge_cnt;
`endif

  int tests = 0;
  int fails = 0;

  freq_gen_nco dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .freq_set       (freq_set),
    .freq_set_valid (freq_set_valid),
    .freq_set_ready (freq_set_ready),
    .gen_en         (gen_en),
    .clk_out        (clk_out),
    .freq_active    (freq_active),
    .inc_active     (inc_active),
    .busy           (busy),
    .err_range      (err_range)
`ifdef FREQ_GEN_EDGE_CNT_EN
    ,
    .edge_cnt_clr   (edge_cnt_clr),
    .edge_cnt       (edge_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference: increment = floor(f * 2^32 / 100e6).
  function automatic logic [31:0] model_inc(input logic [33:0] f);
    logic [65:0] num;
    num = {f, 32'b0};
    return 32'(num / 66'd100_000_000);
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input longint obs, input longint lo, input longint hi);
    tests++;
    assert (obs >= lo && obs <= hi) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic wait_ready(input string tag, output int n_low);
    n_low = 0;
    while (freq_set_ready !== 1'b1 && n_low < 400) begin
      step();
      n_low++;
    end
    if (freq_set_ready !== 1'b1) chk({tag, "_timeout"}, 64'(freq_set_ready), 64'(1));
  endtask

  task automatic request(input logic [33:0] f, input string tag, output int n_low);
    int dummy;
    wait_ready({tag, "_pre"}, dummy);
    freq_set       = f;
    freq_set_valid = 1'b1;
    step();
    freq_set_valid = 1'b0;
    wait_ready(tag, n_low);
  endtask

  // Out-of-range request: one err pulse, ready back after one cycle, setting kept.
  task automatic reject_test(input logic [33:0] f, input string tag);
    logic [31:0] inc0;
    logic [33:0] frq0;
    int          dummy;
    int          errs;
    inc0 = inc_active;
    frq0 = freq_active;
    wait_ready({tag, "_pre"}, dummy);
    freq_set       = f;
    freq_set_valid = 1'b1;
    step();
    freq_set_valid = 1'b0;
    chk({tag, "_ready_low"}, 64'(freq_set_ready), 64'(0));
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) chk({tag, "_ready_back"}, 64'(freq_set_ready), 64'(1));
      errs += int'(err_range);
      step();
    end
    chk({tag, "_err_pulses"}, 64'(errs), 64'(1));
    chk({tag, "_inc_kept"}, 64'(inc_active), 64'(inc0));
    chk({tag, "_freq_kept"}, 64'(freq_active), 64'(frq0));
  endtask

  initial begin
    int          n_low;
    int          cnt;
    int          h;
    int          l;
    logic        prev;
    logic [33:0] f;
    longint      exp_e;

    sys_rst        = 1'b1;
    gen_en         = 1'b0;
    freq_set       = '0;
    freq_set_valid = 1'b0;
`ifdef FREQ_GEN_EDGE_CNT_EN
    edge_cnt_clr   = 1'b0;
`endif
    repeat (3) step();
    sys_rst = 1'b0;
    step();

    // Reset values.
    chk("rst_ready", 64'(freq_set_ready), 64'(1));
    chk("rst_clk_out", 64'(clk_out), 64'(0));
    chk("rst_freq", 64'(freq_active), 64'(0));
    chk("rst_inc", 64'(inc_active), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err_range), 64'(0));

    // 25 MHz: 1 CHECK + 66 DIV + 1 APPLY cycles of ready low.
    gen_en = 1'b1;
    request(34'd25_000_000, "f25", n_low);
    chk("f25_ready_low_cycles", 64'(n_low), 64'(68));
    chk("f25_inc", 64'(inc_active), 64'h4000_0000);
    chk("f25_freq", 64'(freq_active), 64'd25_000_000);
    chk("f25_busy_done", 64'(busy), 64'(0));
    prev = clk_out;
    cnt  = 0;
    while (!(prev == 1'b0 && clk_out == 1'b1) && cnt < 20) begin
      prev = clk_out;
      step();
      cnt++;
    end
    h = 0;
    while (clk_out == 1'b1 && h < 10) begin step(); h++; end
    l = 0;
    while (clk_out == 1'b0 && l < 10) begin step(); l++; end
    chk("f25_high_cycles", 64'(h), 64'(2));
    chk("f25_low_cycles", 64'(l), 64'(2));

    // Rejections while running at 25 MHz, including the first value above F/2.
    reject_test(34'd60_000_000, "rej60M");
    reject_test(34'd50_000_001, "rej_boundary");

    // gen_en 1->0 forces clk_out low within 2 cycles.
    cnt = 0;
    while (clk_out != 1'b1 && cnt < 10) begin step(); cnt++; end
    gen_en = 1'b0;
    step();
    step();
    chk("gen_en_off_clk_out", 64'(clk_out), 64'(0));
    gen_en = 1'b1;
    step();

    // 50 MHz (upper boundary): toggles every cycle.
    request(34'd50_000_000, "f50", n_low);
    chk("f50_inc", 64'(inc_active), 64'h8000_0000);
    step();
    prev = clk_out;
    cnt  = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (clk_out != prev) cnt++;
      prev = clk_out;
    end
    chk("f50_toggles", 64'(cnt), 64'(10));

    // 1 Hz: the switch lands on a wrap, so no stray high after the last pulse.
    request(34'd1, "f1", n_low);
    chk("f1_inc", 64'(inc_active), 64'd42);
    chk("f1_freq", 64'(freq_active), 64'd1);
    step();
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      cnt += int'(clk_out);
      step();
    end
    chk("f1_no_runt_high", 64'(cnt), 64'(0));

    // 0 Hz: increment 0, constant output.
    gen_en = 1'b0;
    request(34'd0, "f0", n_low);
    chk("f0_inc", 64'(inc_active), 64'(0));
    chk("f0_freq", 64'(freq_active), 64'(0));
    gen_en = 1'b1;
    step();
    step();
    prev = clk_out;
    cnt  = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (clk_out != prev) cnt++;
    end
    chk("f0_constant", 64'(cnt), 64'(0));

    // Reset in the middle of DIV.
    freq_set       = 34'd10_000_000;
    freq_set_valid = 1'b1;
    step();
    freq_set_valid = 1'b0;
    repeat (31) step();
    chk("middiv_busy", 64'(busy), 64'(1));
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    chk("middiv_rst_ready", 64'(freq_set_ready), 64'(1));
    chk("middiv_rst_busy", 64'(busy), 64'(0));
    chk("middiv_rst_inc", 64'(inc_active), 64'(0));
    chk("middiv_rst_freq", 64'(freq_active), 64'(0));
    chk("middiv_rst_clk_out", 64'(clk_out), 64'(0));
    request(34'd10_000_000, "f10", n_low);
    chk("f10_inc", 64'(inc_active), 64'd429_496_729);
    chk("f10_ready_low_cycles", 64'(n_low), 64'(68));

    // Random in-range requests: increment vs model, then average frequency.
    for (int k = 0; k < 6; k++) begin
      gen_en = 1'b0;
      f = 34'($urandom_range(100_000, 50_000_000));
      request(f, "rand", n_low);
      chk("rand_inc", 64'(inc_active), 64'(model_inc(f)));
      chk("rand_freq", 64'(freq_active), 64'(f));
      gen_en = 1'b1;
      step();
      step();
      prev = clk_out;
      cnt  = 0;
      for (int i = 0; i < 3000; i++) begin
        step();
        if (prev == 1'b0 && clk_out == 1'b1) cnt++;
        prev = clk_out;
      end
      exp_e = (longint'(model_inc(f)) * 3000) >>> 32;
      chk_range("rand_rising_edges", longint'(cnt), exp_e - 1, exp_e + 1);
    end

    // Random out-of-range requests.
    for (int k = 0; k < 3; k++) begin
      f = 34'd50_000_001 + 34'($urandom);
      reject_test(f, "rand_rej");
    end

`ifdef FREQ_GEN_EDGE_CNT_EN
    gen_en = 1'b0;
    request(34'd25_000_000, "ec25", n_low);
    gen_en       = 1'b1;
    edge_cnt_clr = 1'b1;
    step();
    edge_cnt_clr = 1'b0;
    repeat (4000) step();
    chk_range("edge_cnt_4000", longint'(edge_cnt), 999, 1001);
    prev = clk_out;
    cnt  = 0;
    while (!(prev == 1'b1 && clk_out == 1'b0) && cnt < 20) begin
      prev = clk_out;
      step();
      cnt++;
    end
    step();
    edge_cnt_clr = 1'b1;
    step();
    edge_cnt_clr = 1'b0;
    chk("edge_clr_coincident_rise", 64'(clk_out), 64'(1));
    chk("edge_clr_wins", 64'(edge_cnt), 64'(0));
    repeat (4) step();
    chk("edge_cnt_after_clr", 64'(edge_cnt), 64'(1));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/freq_gen_nco.md
Name: freq_gen_nco

Overview:
- Programmable square-wave test-clock generator; the transmit-side counterpart to the frequency meter.
- Takes a target frequency in Hz, the same 34-bit unit the meter reports.
- Computes a phase increment with a sequential divider and drives a phase-accumulator NCO clocked by the 100 MHz standard clock.
- The output feeds the meter's clk_test input or a pin, giving a closed-loop self-test.

Parameters:
- CLK_STAND_FREQ, 100_000_000: standard clock frequency in Hz.
- FREQ_W, 34: width of requested frequency.
- ACC_W, 32: phase accumulator width.

Ports:
- sys_clk  in  1  standard clock; the single clock domain.
- sys_rst  in  1  synchronous reset, active-high.
- freq_set  in  FREQ_W  requested output frequency in Hz.
- freq_set_valid  in  1  request strobe.
- freq_set_ready  out  1  block can accept a request.
- gen_en  in  1  enable; when 0 the accumulator is held at 0 and clk_out is 0.
- clk_out  out  1  generated square wave, registered.
- freq_active  out  FREQ_W  frequency currently applied.
- inc_active  out  ACC_W  phase increment currently applied.
- busy  out  1  a request is being processed.
- err_range  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset values: freq_set_ready=1, clk_out=0, freq_active=0, inc_active=0, busy=0, err_range=0, accumulator=0, state=IDLE.
- Handshake: a request is accepted on a cycle with freq_set_valid && freq_set_ready. freq_set is captured in that cycle and ready drops the next cycle. Ready is 1 only in IDLE.
- FSM states:
  - IDLE: on accept → CHECK.
  - CHECK (1 cycle):
    - freq_set > CLK_STAND_FREQ/2: pulse err_range, keep the old setting, → IDLE.
    - freq_set == 0: increment is 0, → APPLY.
    - Otherwise → DIV.
  - DIV: restoring division of (freq_set << ACC_W) by CLK_STAND_FREQ. The dividend is FREQ_W+ACC_W bits and one quotient bit is resolved per cycle, so DIV takes exactly FREQ_W+ACC_W = 66 cycles. Quotient = floor(freq·2^ACC_W / CLK_STAND_FREQ), truncated to ACC_W bits (it always fits because freq ≤ F/2). → APPLY.
  - APPLY: the new increment loads in the cycle the accumulator wraps (acc + inc_active ≥ 2^ACC_W), so there is no runt pulse. It loads immediately if inc_active==0 or gen_en==0. On load, update inc_active and freq_active together, then → IDLE.
- busy = 1 in CHECK, DIV and APPLY.
- NCO: each cycle with gen_en=1, acc ← acc + inc_active (mod 2^ACC_W).
- clk_out is registered acc[ACC_W-1], one cycle after the accumulator.
- With gen_en=0: acc ← 0 and clk_out=0 the next cycle. The FSM still runs and APPLY loads immediately.
- Average output frequency = inc_active·CLK_STAND_FREQ/2^ACC_W. Jitter is at most 1 sys_clk period.
- freq_set_valid while not ready is ignored; there is no queueing.
- sys_rst at any point, including mid-DIV, returns everything to reset values the next cycle and discards any partial result.

Optional Feature:
- Macro: FREQ_GEN_EDGE_CNT_EN.
- When defined:
  - Adds output edge_cnt [47:0], counting rising edges of clk_out.
  - Adds input edge_cnt_clr; 1 clears edge_cnt the next cycle, and clear wins over a simultaneous increment.
  - edge_cnt wraps at 2^48 and resets to 0.
- When undefined: both ports and the counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset, gen_en=1, request freq_set=25_000_000 → ready low for 1+66+apply cycles. Then inc_active=0x4000_0000, freq_active=25_000_000, and clk_out has period 4 cycles (2 high, 2 low).
- Request 50_000_000 → inc_active=0x8000_0000 and clk_out toggles every cycle. Then request 1 → inc_active=42 (floor of 42.949); the change lands only on a wrap cycle with no glitch.
- Request 60_000_000 while running at 25 MHz → err_range pulses for exactly 1 cycle, ready returns in 2 cycles, and freq_active/inc_active are unchanged.
- Request 0 → inc_active=0 and clk_out settles to a constant level. Toggle gen_en 1→0 → clk_out=0 within 2 cycles.
- Assert sys_rst at cycle 30 of DIV for a 10_000_000 request → all outputs return to reset values and ready=1. A fresh 10_000_000 request then gives inc_active=429_496_729.
- With FREQ_GEN_EDGE_CNT_EN, run at 25 MHz for 4000 cycles → edge_cnt=1000 ±1. edge_cnt_clr and a rising edge in the same cycle → edge_cnt=0.
